// File: rtl/softmax_scheduler.sv
// Round-robin scheduler sharing one softmax engine between NUM_REQ lanes,
// with argmax post-processing, per-lane response handshake and a watchdog.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   req_valid      per-lane request
//   req_ready      one-hot accept pulse (combinational, IDLE only)
//   req_logits     lane i logits in slice i
//   rsp_valid      one-hot result valid to granted lane
//   rsp_ready      per-lane result accept
//   rsp_probs      captured probabilities (shared bus)
//   rsp_class      argmax index, 4'hF on timeout
//   sm_logits      engine logits, held from grant to next grant
//   sm_in_valid    engine start pulse
//   sm_probs       engine probabilities
//   sm_out_valid   engine done level
//   busy           state != IDLE
//   err_timeout    sticky watchdog flag
module softmax_scheduler #(
   parameter int NUM_REQ    = 4,
   parameter int N_CLASSES  = 10,
   parameter int DW         = 16,
   parameter int SM_LATENCY = 46,
   parameter int TIMEOUT    = 255
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ-1:0]             req_valid,
   output logic [NUM_REQ-1:0]             req_ready,
   input  logic [NUM_REQ*N_CLASSES*DW-1:0] req_logits,
   output logic [NUM_REQ-1:0]             rsp_valid,
   input  logic [NUM_REQ-1:0]             rsp_ready,
   output logic [N_CLASSES*DW-1:0]        rsp_probs,
   output logic [3:0]                     rsp_class,
   output logic [N_CLASSES*DW-1:0]        sm_logits,
   output logic                           sm_in_valid,
   input  logic [N_CLASSES*DW-1:0]        sm_probs,
   input  logic                           sm_out_valid,
   output logic                           busy,
   output logic                           err_timeout
);

   localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam int VW = N_CLASSES * DW;
   localparam logic [CW-1:0] LAT_C = CW'(SM_LATENCY);
   localparam logic [CW-1:0] TMO_C = CW'(TIMEOUT);
   localparam logic [3:0]    LAST_C = 4'(N_CLASSES - 1);

   typedef enum logic [2:0] {
      IDLE, LAUNCH, WAIT, ARGMAX, RESP
   } state_t;

   state_t          state;
   logic [GW-1:0]   last_grant;
   logic [GW-1:0]   grant;
   logic [GW-1:0]   pick;
   logic            found;
   logic [CW-1:0]   cnt;
   logic [3:0]      idx;
   logic [3:0]      best_idx;
   logic [DW-1:0]   best_val;
   logic [DW-1:0]   cand;
   logic            upd;
   logic [3:0]      new_idx;
   logic [DW-1:0]   new_val;

   // Search from last_grant+1 with wrap; descending loop so the
   // nearest requester overwrites farther ones.
   always_comb begin
      int j;
      logic [GW-1:0] jj;
      found = 1'b0;
      pick  = '0;
      j     = 0;
      jj    = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         j = int'(last_grant) + k;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         jj = GW'(j);
         if (req_valid[jj]) begin
            found = 1'b1;
            pick  = jj;
         end
      end
   end

   assign req_ready = (state == IDLE && found)
                    ? (NUM_REQ'(1) << pick) : '0;
   assign busy = (state != IDLE);

   // Strictly-greater update keeps the lowest index on ties.
   assign cand    = rsp_probs[int'(idx)*DW +: DW];
   assign upd     = (idx == 4'd0) || (cand > best_val);
   assign new_idx = upd ? idx : best_idx;
   assign new_val = upd ? cand : best_val;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         last_grant  <= GW'(NUM_REQ - 1);
         grant       <= '0;
         cnt         <= '0;
         idx         <= '0;
         best_idx    <= '0;
         best_val    <= '0;
         sm_logits   <= '0;
         sm_in_valid <= 1'b0;
         rsp_probs   <= '0;
         rsp_class   <= '0;
         rsp_valid   <= '0;
         err_timeout <= 1'b0;
      end else begin
         sm_in_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (found) begin
                  grant       <= pick;
                  sm_logits   <= req_logits[int'(pick)*VW +: VW];
                  sm_in_valid <= 1'b1;
                  state       <= LAUNCH;
               end
            end
            LAUNCH: begin
               cnt   <= '0;
               state <= WAIT;
            end
            WAIT: begin
               if (cnt >= LAT_C && sm_out_valid) begin
                  rsp_probs <= sm_probs;
                  idx       <= '0;
                  state     <= ARGMAX;
               end else if (cnt == TMO_C) begin
                  err_timeout <= 1'b1;
                  rsp_probs   <= '0;
                  rsp_class   <= 4'hF;
                  rsp_valid   <= NUM_REQ'(1) << grant;
                  state       <= RESP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ARGMAX: begin
               best_idx <= new_idx;
               best_val <= new_val;
               if (idx == LAST_C) begin
                  rsp_class <= new_idx;
                  rsp_valid <= NUM_REQ'(1) << grant;
                  state     <= RESP;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready[grant]) begin
                  rsp_valid  <= '0;
                  last_grant <= grant;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_softmax_scheduler.sv
// Directed testbench for softmax_scheduler with a behavioural engine stub.
// Ports of the DUT are all driven/observed here; checks use assertions.
module tb_softmax_scheduler;

   localparam int NR = 4;
   localparam int NC = 10;
   localparam int DW = 16;
   localparam int VW = NC * DW;

   logic             clk = 1'b0;
   logic             rst;
   logic [NR-1:0]    req_valid;
   logic [NR-1:0]    req_ready;
   logic [NR*VW-1:0] req_logits;
   logic [NR-1:0]    rsp_valid;
   logic [NR-1:0]    rsp_ready;
   logic [VW-1:0]    rsp_probs;
   logic [3:0]       rsp_class;
   logic [VW-1:0]    sm_logits;
   logic             sm_in_valid;
   logic [VW-1:0]    sm_probs;
   logic             sm_out_valid;
   logic             busy;
   logic             err_timeout;

   logic [DW-1:0] lg [NR][NC];
   logic [VW-1:0] ovr_vec;
   logic          ovr;
   int            emode;
   int            ecnt = 0;
   int            cyc = 0;
   int            checks = 0;
   int            errors = 0;
   int            siv_n = 0;
   int            siv_at = -1;
   logic          onehot_bad = 1'b0;

   softmax_scheduler dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_logits(req_logits),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_probs(rsp_probs), .rsp_class(rsp_class),
      .sm_logits(sm_logits), .sm_in_valid(sm_in_valid),
      .sm_probs(sm_probs), .sm_out_valid(sm_out_valid),
      .busy(busy), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always_comb begin
      req_logits = '0;
      for (int i = 0; i < NR; i++)
         for (int c = 0; c < NC; c++)
            req_logits[(i*NC+c)*DW +: DW] = lg[i][c];
   end

   // Engine stub: done level rises 45 WAIT counts after launch
   // (mode 0), never (mode 1), or is stuck high (mode 2).
   always @(posedge clk)
      if (sm_in_valid) ecnt <= 1;
      else if (ecnt != 0 && ecnt < 1000) ecnt <= ecnt + 1;
   assign sm_out_valid = (emode == 2) || (emode == 0 && ecnt >= 46);
   assign sm_probs = ovr ? ovr_vec : sm_logits;

   always @(negedge clk) begin
      if (sm_in_valid) begin
         siv_n = siv_n + 1;
         siv_at = cyc;
      end
      if (!$onehot0(req_ready)) onehot_bad = 1'b1;
   end

   function automatic logic [VW-1:0] pack(input int lane);
      logic [VW-1:0] v;
      v = '0;
      for (int c = 0; c < NC; c++) v[c*DW +: DW] = lg[lane][c];
      return v;
   endfunction

   function automatic int idx_of(input logic [NR-1:0] v);
      for (int i = 0; i < NR; i++) if (v[i]) return i;
      return -1;
   endfunction

   task automatic chk(input string tag,
                      input logic [VW-1:0] obs,
                      input logic [VW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_rsp(input int budget, output int at);
      at = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (rsp_valid != '0) begin
            at = cyc;
            break;
         end
      end
   endtask

   initial begin
      int t0, at, n;
      int g [4];
      logic [VW-1:0] hp;
      rst = 1'b1;
      req_valid = '0;
      rsp_ready = '0;
      emode = 0;
      ovr = 1'b0;
      ovr_vec = '0;
      for (int i = 0; i < NR; i++)
         for (int c = 0; c < NC; c++) lg[i][c] = '0;
      lg[0][3] = 16'h0400;
      lg[1][9] = 16'h0010;
      lg[2][0] = 16'h0005;
      lg[3][1] = 16'h0007;
      for (int c = 0; c < NC; c++) ovr_vec[c*DW +: DW] = 16'h1000;
      ovr_vec[4*DW +: DW] = 16'h2000;
      ovr_vec[7*DW +: DW] = 16'h2000;

      repeat (3) @(negedge clk);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_probs", rsp_probs, 0);
      chk("rst_rsp_class", rsp_class, 0);
      chk("rst_sm_logits", sm_logits, 0);
      chk("rst_sm_in_valid", sm_in_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err_timeout, 0);
      rst = 1'b0;
      @(negedge clk);

      // Single lane 0 job, latency profile
      req_valid = 4'b0001;
      #1;
      t0 = cyc;
      chk("t1_req_ready", req_ready, 4'b0001);
      @(negedge clk);
      req_valid = '0;
      chk("t1_sm_logits", sm_logits, pack(0));
      chk("t1_busy", busy, 1);
      wait_rsp(100, at);
      chk("t1_rsp_at", at, t0 + 59);
      chk("t1_start_at", siv_at, t0 + 1);
      chk("t1_start_n", siv_n, 1);
      chk("t1_rsp_valid", rsp_valid, 4'b0001);
      chk("t1_class", rsp_class, 3);
      chk("t1_probs", rsp_probs, pack(0));
      rsp_ready = 4'b0001;
      @(negedge clk);
      chk("t1_rsp_drop", rsp_valid, 0);
      chk("t1_idle", busy, 0);
      rsp_ready = '0;

      // Round robin: last grant was lane 0 -> 1,2,0,1
      rsp_ready = 4'hF;
      req_valid = 4'b0111;
      n = 0;
      for (int i = 0; i < 400; i++) begin
         #1;
         if (req_ready != '0) begin
            g[n] = idx_of(req_ready);
            n++;
         end
         if (n == 4) break;
         @(negedge clk);
      end
      @(negedge clk);
      req_valid = '0;
      chk("rr_count", n, 4);
      chk("rr_g0", g[0], 1);
      chk("rr_g1", g[1], 2);
      chk("rr_g2", g[2], 0);
      chk("rr_g3", g[3], 1);
      for (int i = 0; i < 100 && busy; i++) @(negedge clk);
      chk("rr_idle", busy, 0);
      rsp_ready = '0;

      // Tie between classes 4 and 7 resolves to 4
      ovr = 1'b1;
      req_valid = 4'b1000;
      #1;
      t0 = cyc;
      chk("tie_req_ready", req_ready, 4'b1000);
      @(negedge clk);
      req_valid = '0;
      wait_rsp(100, at);
      chk("tie_rsp_at", at, t0 + 59);
      chk("tie_rsp_valid", rsp_valid, 4'b1000);
      chk("tie_class", rsp_class, 4);
      chk("tie_probs", rsp_probs, ovr_vec);
      rsp_ready = 4'b1000;
      @(negedge clk);
      rsp_ready = '0;
      ovr = 1'b0;

      // Lane 1 stalls its response for 20 cycles
      req_valid = 4'b0010;
      #1;
      chk("hold_req_ready", req_ready, 4'b0010);
      @(negedge clk);
      req_valid = '0;
      wait_rsp(100, at);
      chk("hold_class", rsp_class, 9);
      hp = rsp_probs;
      chk("hold_probs0", hp, pack(1));
      req_valid = 4'b0001;
      rsp_ready = 4'b0001;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("hold_valid", rsp_valid, 4'b0010);
         chk("hold_probs", rsp_probs, hp);
         chk("hold_no_accept", req_ready, 0);
      end
      rsp_ready = 4'b0010;
      emode = 1;
      @(negedge clk);
      chk("hold_release", rsp_valid, 0);
      chk("hold_next_grant", req_ready, 4'b0001);
      t0 = cyc;
      rsp_ready = '0;
      @(negedge clk);
      req_valid = '0;

      // Engine never finishes: watchdog
      wait_rsp(300, at);
      chk("to_rsp_at", at, t0 + 258);
      chk("to_err", err_timeout, 1);
      chk("to_class", rsp_class, 4'hF);
      chk("to_probs", rsp_probs, 0);
      chk("to_rsp_valid", rsp_valid, 4'b0001);
      rsp_ready = 4'b0001;
      @(negedge clk);
      rsp_ready = '0;
      emode = 2;

      // Stale done level, then reset mid-WAIT
      req_valid = 4'b0100;
      #1;
      t0 = cyc;
      chk("st_req_ready", req_ready, 4'b0100);
      chk("st_err_sticky", err_timeout, 1);
      @(negedge clk);
      req_valid = '0;
      repeat (46) @(negedge clk);
      chk("st_cycle", cyc, t0 + 47);
      chk("st_no_capture", rsp_probs, 0);
      chk("st_busy", busy, 1);
      chk("st_no_rsp", rsp_valid, 0);
      rst = 1'b1;
      #1;
      chk("ar_busy", busy, 0);
      chk("ar_err", err_timeout, 0);
      chk("ar_sm_logits", sm_logits, 0);
      chk("ar_rsp_class", rsp_class, 0);
      chk("ar_rsp_probs", rsp_probs, 0);
      chk("ar_rsp_valid", rsp_valid, 0);
      @(negedge clk);
      rst = 1'b0;
      emode = 0;
      req_valid = 4'b0011;
      #1;
      chk("ar_first_grant", req_ready, 4'b0001);
      @(negedge clk);
      req_valid = '0;
      wait_rsp(100, at);
      chk("ar_class", rsp_class, 3);
      rsp_ready = 4'b0001;
      @(negedge clk);
      rsp_ready = '0;

      chk("onehot_ready", onehot_bad, 0);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
